// File: rtl/dmem_responder.sv
// dmem_responder
//   Fixed-latency data-memory responder for the processor DMEM port.
//   It accepts one load or store per request, latches the request and
//   completes it LATENCY clock edges later. Byte, halfword and word lanes are
//   big-endian (bit 0 is the MSB). Byte and halfword loads are right-justified
//   and can optionally be sign-extended.
//
// Parameters
//   ADDR_BITS : word-address width; storage is 2**ADDR_BITS 32-bit words
//   LATENCY   : edges from acceptance to completion, 1..16
//
// Ports
//   clock               : system clock, rising edge
//   reset               : asynchronous active-low reset
//   req_to_mem          : request valid, held until mem_done
//   addr_to_mem         : byte address
//   write_enable_to_mem : 1 = store, 0 = load
//   byte_to_mem         : byte access (wins over half_word_to_mem)
//   half_word_to_mem    : halfword access
//   sign_extend_to_mem  : sign-extend byte/halfword loads
//   data_to_mem         : right-justified store data
//   data_from_mem       : registered load result
//   mem_stall           : hold the pipe while an access is outstanding
//   mem_done            : one-cycle completion pulse
module dmem_responder #(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_to_mem,
  input  logic [0:31] addr_to_mem,
  input  logic        write_enable_to_mem,
  input  logic        byte_to_mem,
  input  logic        half_word_to_mem,
  input  logic        sign_extend_to_mem,
  input  logic [0:31] data_to_mem,
  output logic [0:31] data_from_mem,
  output logic        mem_stall,
  output logic        mem_done
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state;
  logic [3:0]             cnt;
  logic [ADDR_BITS-1:0]   idx_q;
  logic [1:0]             lane_q;
  logic [0:31]            data_q;
  logic                   we_q;
  logic                   byte_q;
  logic                   half_q;
  logic                   sx_q;

  logic [0:31]            mem_array [0:(1 << ADDR_BITS) - 1];

  logic [0:31]            cur_word;
  logic [0:31]            wr_word;
  logic [0:31]            ld_word;
  logic [7:0]             lane8;
  logic [15:0]            lane16;

  // Address bits above the word index alias the array and are intentionally
  // dropped; this reduction keeps every input bit referenced.
  logic                   unused_addr_bits;
  assign unused_addr_bits = ^addr_to_mem;

  assign mem_stall = reset & ((state == BUSY) | ((state == IDLE) & req_to_mem));

  // Read-modify-write merge for stores and lane extraction for loads.
  always_comb begin
    cur_word = mem_array[idx_q];
    wr_word  = cur_word;
    lane8    = '0;
    lane16   = '0;
    ld_word  = '0;
    if (byte_q) begin
      case (lane_q)
        2'd0: begin lane8 = cur_word[0:7];   wr_word[0:7]   = data_q[24:31]; end
        2'd1: begin lane8 = cur_word[8:15];  wr_word[8:15]  = data_q[24:31]; end
        2'd2: begin lane8 = cur_word[16:23]; wr_word[16:23] = data_q[24:31]; end
        default: begin lane8 = cur_word[24:31]; wr_word[24:31] = data_q[24:31]; end
      endcase
      ld_word = {{24{sx_q & lane8[7]}}, lane8};
    end else if (half_q) begin
      if (lane_q[1]) begin
        lane16         = cur_word[16:31];
        wr_word[16:31] = data_q[16:31];
      end else begin
        lane16         = cur_word[0:15];
        wr_word[0:15]  = data_q[16:31];
      end
      ld_word = {{16{sx_q & lane16[15]}}, lane16};
    end else begin
      wr_word = data_q;
      ld_word = cur_word;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      idx_q         <= '0;
      lane_q        <= '0;
      data_q        <= '0;
      we_q          <= 1'b0;
      byte_q        <= 1'b0;
      half_q        <= 1'b0;
      sx_q          <= 1'b0;
      data_from_mem <= '0;
      mem_done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_done <= 1'b0;
          if (req_to_mem) begin
            idx_q  <= addr_to_mem[30-ADDR_BITS:29];
            lane_q <= addr_to_mem[30:31];
            data_q <= data_to_mem;
            we_q   <= write_enable_to_mem;
            byte_q <= byte_to_mem;
            half_q <= half_word_to_mem;
            sx_q   <= sign_extend_to_mem;
            cnt    <= 4'(LATENCY - 1);
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            if (!we_q) data_from_mem <= ld_word;
            mem_done <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          mem_done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          mem_done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Storage is not reset. An asserted reset forces IDLE, so a pending store
  // can never reach this write.
  always_ff @(posedge clock) begin
    if (reset && state == BUSY && cnt == 4'd0 && we_q)
      mem_array[idx_q] <= wr_word;
  end

endmodule
